// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor and its synchronizer.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PRST,
    WLOCK,
    STAB,
    RUN,
    FAIL
  } sup_state_e;

  localparam int ATTEMPT_W  = 3;
  localparam int LOSS_W     = 8;
  localparam int FILT_LEN   = 8;
  localparam int FILT_CNT_W = $clog2(FILT_LEN);

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Controller-side PLL rst/locked interface plus the supervisor's status outputs.
interface pll_lock_supervisor_if;

  logic                             locked;
  logic                             relock_req;
  logic                             pll_rst;
  logic                             sys_rst_n;
  logic                             ready;
  logic                             fail;
  logic [pll_sup_pkg::ATTEMPT_W-1:0] attempt;
  logic [pll_sup_pkg::LOSS_W-1:0]    loss_cnt;

  // The supervisor is the master: it drives the PLL reset and the status lines.
  modport master (
    input  locked, relock_req,
    output pll_rst, sys_rst_n, ready, fail, attempt, loss_cnt
  );

  modport slave (
    output locked, relock_req,
    input  pll_rst, sys_rst_n, ready, fail, attempt, loss_cnt
  );

endinterface

// File: rtl/pll_sup_sync.sv
// Two-flop synchronizer for an asynchronous status level, with an optional
// 8-cycle debounce selected by PLL_LOCK_GLITCH_FILTER_EN.
module pll_sup_sync
  import pll_sup_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic lk_p0_q;
  logic lk_p1_q;

  // Stage p0: metastability capture; stage p1: settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_p0_q <= 1'b0;
      lk_p1_q <= 1'b0;
    end else begin
      lk_p0_q <= async_in;
      lk_p1_q <= lk_p0_q;
    end
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  logic                  filt_q, filt_d;
  logic [FILT_CNT_W-1:0] fcnt_q, fcnt_d;

  // Filter stage: the output follows p1 only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (lk_p1_q != filt_q) begin
      if (fcnt_q == FILT_CNT_W'(FILT_LEN - 1)) begin
        filt_d = lk_p1_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign sync_out = filt_q;
`else
  assign sync_out = lk_p1_q;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, releases sys_rst_n and
// retries on timeout or lock loss. Build option: PLL_LOCK_GLITCH_FILTER_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  pll_lock_supervisor_if.master  bus
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]     RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ATTEMPT_W-1:0] ATT_MAX   = ATTEMPT_W'(MAX_RETRIES);

  logic lk_s;

  pll_sup_sync u_sync (
    .clk      (refclk),
    .rst_n    (rst_n),
    .async_in (bus.locked),
    .sync_out (lk_s)
  );

  sup_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ATTEMPT_W-1:0] attempt_q, attempt_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_rst_n_q, sys_rst_n_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    loss_d    = loss_q;

    if (bus.relock_req) begin
      state_d   = PRST;
      attempt_d = '0;
    end else begin
      case (state_q)
        PRST: begin
          if (cnt_q == RST_LAST) state_d = WLOCK;
        end
        WLOCK: begin
          // Lock seen on the timeout cycle still counts as a lock.
          if (lk_s) begin
            state_d = STAB;
          end else if (cnt_q == TMO_LAST) begin
            attempt_d = attempt_q + 1'b1;
            state_d   = (attempt_d == ATT_MAX) ? FAIL : PRST;
          end
        end
        STAB: begin
          if (!lk_s) begin
            state_d = WLOCK;
          end else if (cnt_q == STAB_LAST) begin
            state_d   = RUN;
            attempt_d = '0;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d = PRST;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = PRST;
        end
      endcase
    end

    // The shared counter restarts on any transition and on a relock restart.
    if (bus.relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == PRST) || (state_q == WLOCK) || (state_q == STAB)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    pll_rst_d   = (state_d == PRST);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRST;
      cnt_q       <= '0;
      attempt_q   <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      attempt_q   <= attempt_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.attempt   = attempt_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Controls the reset input of the fabric PLL and consumes its locked output; this is the controller side of the PLL rst/locked interface.
- Pulses the PLL reset and waits for lock with a timeout.
- Requires lock to stay stable for a qualification window, then releases the downstream system reset.
- Monitors for lock loss and restarts the sequence, retrying a bounded number of times before flagging failure.
- Clocked by the 50 MHz board reference clock, which is free-running and independent of PLL outputs.

Parameters:
- RST_CYCLES, 16: number of cycles pll_rst is held high per attempt (minimum 1).
- LOCK_TIMEOUT, 50000: cycles to wait for synchronized lock before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive cycles lock must be held before sys_rst_n is released.
- MAX_RETRIES, 4: failed attempts allowed before entering FAIL (minimum 1).

Ports:
- refclk, input, 1: reference clock; the only clock in the block.
- rst_n, input, 1: asynchronous active-low reset.
- locked, input, 1: PLL lock indication; asynchronous to refclk.
- relock_req, input, 1: single-cycle request to restart the sequence, including from FAIL.
- pll_rst, output, 1: active-high reset driven to the PLL.
- sys_rst_n, output, 1: active-low reset for PLL-clocked logic; the consumer synchronizes its deassertion.
- ready, output, 1: high only in RUN.
- fail, output, 1: high only in FAIL.
- attempt, output, 3: number of failed attempts in the current sequence.
- loss_cnt, output, 8: count of lock losses seen while in RUN.

Behaviour:
- Reset values (rst_n low): pll_rst=1, sys_rst_n=0, ready=0, fail=0, attempt=0, loss_cnt=0, state=PRST, all counters 0.
- Lock synchronizer:
  - locked passes through a 2-flop synchronizer to produce lk_s; this gives 2 cycles of latency.
  - All decisions use lk_s only.
- Single shared cycle counter cnt; it clears on every state transition.
- States and transitions:
  - PRST: pll_rst=1. When cnt==RST_CYCLES-1, go to WLOCK.
  - WLOCK: pll_rst=0. If lk_s=1, go to STAB. Otherwise, when cnt==LOCK_TIMEOUT-1, increment attempt.
    - If the new attempt==MAX_RETRIES, go to FAIL.
    - Otherwise, go to PRST.
  - STAB: if lk_s=0, go to WLOCK; attempt is unchanged and the timeout restarts. If cnt==STABLE_CYCLES-1, go to RUN.
  - RUN: sys_rst_n=1 and ready=1, both registered and asserted in the first RUN cycle. attempt clears to 0 on entry.
    - If lk_s=0: loss_cnt increments, saturating at 255; go to PRST. sys_rst_n=0 in the next cycle.
  - FAIL: pll_rst=0, fail=1, sys_rst_n=0. Remains in FAIL until relock_req.
- relock_req:
  - In any state it causes: go to PRST, attempt=0, cnt=0.
  - It has priority over every other transition in the same cycle.
  - loss_cnt is not cleared.
- sys_rst_n is 0 in every state except RUN. Its assertion is combinationally safe because it is registered from the state.
- Boundary cases:
  - lk_s dropping on the exact cycle STAB completes: the drop wins; go to WLOCK.
  - Timeout and lk_s rising in the same cycle: lock wins; go to STAB.
  - rst_n asserted mid-sequence: immediate return to the reset values.
- Counter width: $clog2 of the maximum of LOCK_TIMEOUT, STABLE_CYCLES and RST_CYCLES. Counter comparisons are unsigned.
- Total lock-to-ready latency: 2 synchronizer cycles + STABLE_CYCLES + 1.

Optional Feature:
- Macro: PLL_LOCK_GLITCH_FILTER_EN.
- When defined:
  - lk_s is further debounced: it changes value only after the raw synchronized level has held for 8 consecutive cycles, using a 3-bit counter.
  - Lock losses shorter than 8 cycles are ignored in RUN and STAB.
  - Added latency: 8 cycles.
- When undefined: lk_s is the synchronizer output directly, and no filter logic exists.

Decomposition:
- Package pll_sup_pkg contains:
  - the state enum (PRST, WLOCK, STAB, RUN, FAIL);
  - the width localparams for attempt and loss_cnt;
  - the filter length constant 8.
- One sub-module: pll_sup_sync. It is the 2-flop synchronizer plus the optional glitch filter and is reusable for other asynchronous status inputs.

Test Plan:
1. Reset, then locked=1 from cycle 30 with RST_CYCLES=16 and STABLE_CYCLES=1024:
   - pll_rst high for 16 cycles;
   - ready and sys_rst_n rise exactly 2+1024+1 cycles after locked rises;
   - attempt=0.
2. Lock never asserts, with LOCK_TIMEOUT=100 and MAX_RETRIES=4:
   - four pll_rst pulses of 16 cycles each;
   - attempt steps 1..4, and fail=1 after the 4th timeout;
   - relock_req then gives attempt=0 and pll_rst=1.
3. In RUN, locked drops for 1 cycle:
   - loss_cnt goes 0→1;
   - sys_rst_n=0 and ready=0 within 3 cycles;
   - PRST is re-entered and the full sequence repeats.
4. In STAB, locked drops at cnt=500:
   - return to WLOCK;
   - attempt is unchanged and ready is never asserted;
   - re-lock reaches RUN after a fresh 1024-cycle window.
5. 300 lock-loss events:
   - loss_cnt saturates at 255.
6. With PLL_LOCK_GLITCH_FILTER_EN defined, a 5-cycle locked drop in RUN:
   - no state change and loss_cnt unchanged.
   - A 10-cycle drop then increments loss_cnt and enters PRST.
